// File: rtl/player_pkg.sv
// Shared types, key codes and screen constants for the fighter motion controller.
package player_pkg;

  typedef enum logic [1:0] {
    GROUND  = 2'd0,
    AIR     = 2'd1,
    RESPAWN = 2'd2
  } motion_state_t;

  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;
  localparam logic [7:0] KEY_W = 8'h1A;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  function automatic logic key_down(input logic [15:0] kc, input logic [7:0] key);
    return (kc[15:8] == key) || (kc[7:0] == key);
  endfunction

endpackage

// File: rtl/vsync_tick.sv
// Registers the active-low VGA vsync and emits a one-cycle frame tick
// on the falling edge of the registered copy.
module vsync_tick (
  input  logic clk,
  input  logic reset,
  input  logic vsync,
  output logic tick
);

  logic vs_q, vs_d;
  logic vs_prev_q, vs_prev_d;

  always_comb begin
    vs_d      = vsync;
    vs_prev_d = vs_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vs_q      <= 1'b0;
      vs_prev_q <= 1'b0;
    end else begin
      vs_q      <= vs_d;
      vs_prev_q <= vs_prev_d;
    end
  end

  assign tick = vs_prev_q & ~vs_q;

endmodule

// File: rtl/player_motion.sv
// Per-player sprite motion: walk, jump, gravity, landing, KO and respawn, one step per frame.
// Optional air jump enabled by defining PLAYER_DOUBLE_JUMP_EN.
//
// state   | meaning
// GROUND  | feet on the platform, walking / may jump
// AIR     | ballistic motion under gravity
// RESPAWN | parked at spawn point for RESPAWN_FRAMES frames after a KO
module player_motion
  import player_pkg::*;
#(
  parameter int SPR_W          = 40,
  parameter int SPR_H          = 60,
  parameter int FLOOR_Y        = 360,
  parameter int STAGE_X_MIN    = 80,
  parameter int STAGE_X_MAX    = 560,
  parameter int SPAWN_X        = 300,
  parameter int SPAWN_Y        = 100,
  parameter int WALK_SPEED     = 3,
  parameter int JUMP_VEL       = 12,
  parameter int MAX_FALL       = 8,
  parameter int KILL_Y         = SCREEN_H,
  parameter int RESPAWN_FRAMES = 60
) (
  input  logic        vga_clk,
  input  logic        Reset,
  input  logic        vsync,
  input  logic [15:0] keycode,
  output logic [9:0]  BallX,
  output logic [9:0]  BallY,
  output logic        on_ground,
  output logic        facing_left,
  output logic        ko_pulse,
  output logic [3:0]  ko_count
);

  localparam int RW = $clog2(RESPAWN_FRAMES + 1);

  localparam logic [10:0]        X_MAX     = 11'(SCREEN_W - SPR_W);
  localparam logic [10:0]        STEP      = 11'(WALK_SPEED);
  localparam logic [10:0]        HALF_W    = 11'(SPR_W / 2);
  localparam logic [10:0]        STG_MIN   = 11'(STAGE_X_MIN);
  localparam logic [10:0]        STG_MAX   = 11'(STAGE_X_MAX);
  localparam logic signed [11:0] FLOOR_TOP = 12'(FLOOR_Y - SPR_H);
  localparam logic signed [11:0] KILL_LIM  = 12'(KILL_Y);
  localparam logic signed [5:0]  VY_JUMP   = 6'(-JUMP_VEL);
  localparam logic signed [5:0]  VY_MAX    = 6'(MAX_FALL);
  localparam logic [9:0]         SPAWN_X10 = 10'(SPAWN_X);
  localparam logic signed [10:0] SPAWN_Y11 = 11'(SPAWN_Y);
  localparam logic [RW-1:0]      RESP_LOAD = RW'(RESPAWN_FRAMES);

  motion_state_t            state_q, state_d;
  logic [9:0]               x_q, x_d;
  logic signed [10:0]       y_q, y_d;
  logic signed [5:0]        vy_q, vy_d;
  logic [1:0]               jumps_q, jumps_d;
  logic                     jump_prev_q, jump_prev_d;
  logic                     facing_q, facing_d;
  logic                     on_ground_q, on_ground_d;
  logic                     ko_pulse_q, ko_pulse_d;
  logic [3:0]               ko_cnt_q, ko_cnt_d;
  logic [RW-1:0]            resp_cnt_q, resp_cnt_d;

  logic                     tick;
  logic                     key_l, key_r, key_j, jump_edge, move_l, move_r;
  logic [10:0]              x_sum, foot;
  logic [9:0]               x_mov;
  logic                     over_stage;
  logic signed [11:0]       y_ext, y_next;
  logic signed [5:0]        vy_grav;
  logic                     ko_hit, land, ceil_hit;

  vsync_tick u_vsync_tick (
    .clk   (vga_clk),
    .reset (Reset),
    .vsync (vsync),
    .tick  (tick)
  );

  always_comb begin
    key_l     = key_down(keycode, KEY_A);
    key_r     = key_down(keycode, KEY_D);
    key_j     = key_down(keycode, KEY_W);
    jump_edge = key_j & ~jump_prev_q;
    move_l    = key_l & ~key_r;
    move_r    = key_r & ~key_l;

    // 11-bit working copy so left underflow and right overflow both clamp cleanly
    x_sum = {1'b0, x_q};
    if (move_l)      x_sum = (x_sum < STEP) ? '0 : x_sum - STEP;
    else if (move_r) x_sum = x_sum + STEP;
    x_mov      = (x_sum > X_MAX) ? X_MAX[9:0] : x_sum[9:0];
    foot       = {1'b0, x_mov} + HALF_W;
    over_stage = (foot >= STG_MIN) && (foot <= STG_MAX);

    y_ext    = {y_q[10], y_q};
    y_next   = y_ext + {{6{vy_q[5]}}, vy_q};
    vy_grav  = (vy_q >= VY_MAX) ? VY_MAX : vy_q + 6'sd1;
    ko_hit   = (y_next >= KILL_LIM);
    land     = !vy_q[5] && (y_ext <= FLOOR_TOP) && (y_next >= FLOOR_TOP) && over_stage;
    ceil_hit = y_next[11];
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    vy_d        = vy_q;
    jumps_d     = jumps_q;
    jump_prev_d = jump_prev_q;
    facing_d    = facing_q;
    ko_pulse_d  = 1'b0;
    ko_cnt_d    = ko_cnt_q;
    resp_cnt_d  = resp_cnt_q;

    if (tick) begin
      jump_prev_d = key_j;
      case (state_q)
        GROUND: begin
          x_d = x_mov;
          if (move_l | move_r) facing_d = move_l;
          if (jump_edge) begin
            vy_d    = VY_JUMP;
            jumps_d = 2'd1;
            state_d = AIR;
          end else if (!over_stage) begin
            vy_d    = '0;
            state_d = AIR;
          end
        end
        AIR: begin
          x_d = x_mov;
          if (move_l | move_r) facing_d = move_l;
          y_d  = y_next[10:0];
          vy_d = vy_grav;
`ifdef PLAYER_DOUBLE_JUMP_EN
          if (jump_edge && (jumps_q < 2'd2)) begin
            vy_d    = VY_JUMP;
            jumps_d = 2'd2;
          end
`endif
          if (ko_hit) begin
            state_d    = RESPAWN;
            x_d        = SPAWN_X10;
            y_d        = SPAWN_Y11;
            vy_d       = '0;
            jumps_d    = '0;
            ko_pulse_d = 1'b1;
            if (ko_cnt_q != 4'd15) ko_cnt_d = ko_cnt_q + 4'd1;
            resp_cnt_d = RESP_LOAD;
          end else if (land) begin
            y_d     = FLOOR_TOP[10:0];
            vy_d    = '0;
            jumps_d = '0;
            state_d = GROUND;
          end else if (ceil_hit) begin
            y_d  = '0;
            vy_d = '0;
          end
        end
        RESPAWN: begin
          x_d        = SPAWN_X10;
          y_d        = SPAWN_Y11;
          vy_d       = '0;
          resp_cnt_d = resp_cnt_q - RW'(1);
          if (resp_cnt_q == RW'(1)) state_d = AIR;
        end
        default: state_d = AIR;
      endcase
    end

    on_ground_d = (state_d == GROUND);
  end

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      state_q     <= AIR;
      x_q         <= SPAWN_X10;
      y_q         <= SPAWN_Y11;
      vy_q        <= '0;
      jumps_q     <= '0;
      jump_prev_q <= 1'b0;
      facing_q    <= 1'b0;
      on_ground_q <= 1'b0;
      ko_pulse_q  <= 1'b0;
      ko_cnt_q    <= '0;
      resp_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      vy_q        <= vy_d;
      jumps_q     <= jumps_d;
      jump_prev_q <= jump_prev_d;
      facing_q    <= facing_d;
      on_ground_q <= on_ground_d;
      ko_pulse_q  <= ko_pulse_d;
      ko_cnt_q    <= ko_cnt_d;
      resp_cnt_q  <= resp_cnt_d;
    end
  end

  assign BallX       = x_q;
  assign BallY       = y_q[9:0];
  assign on_ground   = on_ground_q;
  assign facing_left = facing_q;
  assign ko_pulse    = ko_pulse_q;
  assign ko_count    = ko_cnt_q;

endmodule
